// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for a multi-digit common-segment 7-segment display.
// It holds N_DIGITS hex codes, decodes each with the full 0-F font, and scans
// the digit enables at a prescaled rate. New values from a load strobe go
// into a shadow copy and move to the active copy only at a frame wrap, so a
// digit never changes part-way through a frame. All display pins are
// registered, and pin polarity is applied last, in the output register.

module seg7_scan_driver #(
    parameter int N_DIGITS       = 4,     // digits scanned, 2..8
    parameter int SCAN_DIV       = 1000,  // clk cycles per digit slot, >= 2
    parameter bit SEG_ACTIVE_LOW = 1'b0,  // seg/dp lit when 0
    parameter bit DIG_ACTIVE_LOW = 1'b0   // dig enabled when 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   dig,
    output logic                  frame_done,
    output logic                  upd_pending
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(N_DIGITS);

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0]          SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] DIG_OFF  = {N_DIGITS{DIG_ACTIVE_LOW}};

    // Hex font, segments {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] font(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Scan position
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic                  tick;
    logic                  boundary;

    // Shadow (loaded any time) and active (displayed) copies
    logic [4*N_DIGITS-1:0] shadow_data;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic [N_DIGITS-1:0]   shadow_blank;
    logic [4*N_DIGITS-1:0] act_data;
    logic [N_DIGITS-1:0]   act_dp;
    logic [N_DIGITS-1:0]   act_blank;
    logic                  pending;

    // Per-digit decode of the current slot
    logic [N_DIGITS-1:0]   lz_dark;
    logic                  zero_run;
    logic [3:0]            cur_code;
    logic                  cur_dp;
    logic                  cur_dark;
    logic [N_DIGITS-1:0]   cur_sel;

    // A frame wraps on the tick that leaves the last digit; the pulse is the
    // boundary cycle itself, so a load seen alongside it lands in the new frame.
    assign tick        = en && (cnt == CNT_LAST);
    assign boundary    = tick && (idx == IDX_LAST);
    assign frame_done  = boundary;
    assign upd_pending = pending;

    // Prescaler and digit index; both freeze while scanning is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (en) begin
            if (tick) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Shadow capture and tear-free transfer to the active copy at frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_data  <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
            act_data     <= '0;
            act_dp       <= '0;
            act_blank    <= '0;
            pending      <= 1'b0;
        end else begin
            if (load) begin
                shadow_data  <= data_in;
                shadow_dp    <= dp_in;
                shadow_blank <= blank_mask;
            end
            if (boundary && load) begin
                // Coincident load bypasses the shadow so it is not a frame late.
                act_data  <= data_in;
                act_dp    <= dp_in;
                act_blank <= blank_mask;
                pending   <= 1'b0;
            end else if (boundary && pending) begin
                act_data  <= shadow_data;
                act_dp    <= shadow_dp;
                act_blank <= shadow_blank;
                pending   <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Leading-zero map: digit i is suppressible when it and every more
    // significant digit are zero. Digit 0 is never suppressed.
    always_comb begin
        zero_run = 1'b1;
        lz_dark  = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (act_data[4*i +: 4] == 4'h0);
            if (i > 0) begin
                lz_dark[i] = zero_run;
            end
        end
    end

    // Select code, dp and darkness for the digit under the scan index.
    always_comb begin
        cur_code = 4'h0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        cur_sel  = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_code   = act_data[4*i +: 4];
                cur_dp     = act_dp[i];
                cur_dark   = act_blank[i] || (lz_en && lz_dark[i]);
                cur_sel[i] = 1'b1;
            end
        end
    end

    // Output register: dark digits keep their enable but show nothing;
    // disabled scanning turns everything off. Polarity is applied here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            dp  <= SEG_ACTIVE_LOW;
            dig <= DIG_OFF;
        end else if (!en) begin
            seg <= SEG_OFF;
            dp  <= SEG_ACTIVE_LOW;
            dig <= DIG_OFF;
        end else begin
            seg <= (cur_dark ? 7'h00 : font(cur_code)) ^ SEG_OFF;
            dp  <= (cur_dp && !cur_dark) ^ SEG_ACTIVE_LOW;
            dig <= cur_sel ^ DIG_OFF;
        end
    end

endmodule
